mem_save_block_fifo: RTL and testbench
======================================

Name: mem_save_block_fifo

Overview:
- Parametrised multi-entry successor to the single-register hash block store.
- Buffers up to DEPTH hash blocks/digests (224- or 256-bit) between a SHA-2 core and its consumer.
- Decouples core write timing from downstream read timing using first-word-fall-through (FWFT) FIFO semantics.
- Adds occupancy count, full/empty flags, sticky overflow/underflow error flags and a synchronous clear.

Parameters:
WIDTH, 256, block width in bits; 224 and 256 are the supported uses.
DEPTH, 4, number of entries; power of two, >= 2.
CW, $clog2(DEPTH)+1, count width (derived localparam, not overridable).

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; empties the FIFO and clears the error flags
write_en  input  1  push block_in this cycle
block_in  input  WIDTH  data to push
read_en  input  1  pop head entry this cycle
block_out  output  WIDTH  head entry (FWFT); all zeros when empty
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CW  number of stored entries, 0..DEPTH
overflow  output  1  sticky: a write was dropped because the FIFO was full
underflow  output  1  sticky: a read was issued while the FIFO was empty

Behaviour:
- Reset (RST=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - overflow=0, underflow=0.
  - Outputs: block_out=0, empty=1, full=0.
  - Storage array contents are don't-care; they need not be reset.
- Storage:
  - DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are each clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push accepted: write_en=1 && (!full || read_en).
  - mem[wr_ptr] <= block_in; wr_ptr increments.
- Pop accepted: read_en=1 && !empty.
  - rd_ptr increments.
- Count update on each clock edge:
  - +1 if push only.
  - -1 if pop only.
  - Unchanged if both or neither.
- block_out:
  - Combinational from registered state: mem[rd_ptr] when !empty, else 0.
  - A pushed block appears on block_out the cycle after the write when the FIFO was empty (write-to-read latency is 1 cycle).
- full, empty: combinational decodes of the registered count.
- Full with write_en=1 and read_en=0:
  - Write is dropped; storage and pointers are unchanged.
  - overflow <= 1.
- Full with write_en=1 and read_en=1:
  - Both the pop and the push are accepted.
  - count stays DEPTH; no overflow.
- Empty with read_en=1:
  - Read is ignored; underflow <= 1.
  - This applies even if write_en=1 in the same cycle. The push is still accepted (count 0->1), but read-through of the same-cycle write is not supported.
- overflow and underflow:
  - Remain set until reset or clear.
  - They do not block further operation.
- clear=1 at a clock edge:
  - Pointers, count and both flags go to 0.
  - clear takes priority over write_en/read_en in the same cycle; both are ignored and no flag is set.
  - block_out reads 0 from the next cycle on.
- Reset asserted mid-operation: the FIFO empties immediately, with no wait for a clock edge.
- No X propagation: every output is defined from reset onward.

Test Plan:
1. Reset then idle:
   - Stimulus: RST low 2 cycles, then release.
   - Required: count=0, empty=1, full=0, block_out=0, overflow=0, underflow=0.
2. Fill and drain, DEPTH=4, WIDTH=256:
   - Stimulus: push 0x...01 to 0x...04 on consecutive cycles.
   - Required after the 4th push: full=1, count=4.
   - Then pop 4 times; block_out shows 0x01, 0x02, 0x03, 0x04 in order, then empty=1 and block_out=0.
3. Overflow:
   - Stimulus: with the FIFO full, push 0xDEAD.
   - Required: overflow=1, count=4, and the entries still drain as 0x01..0x04 (0xDEAD never appears).
   - Underflow: pop while empty -> underflow=1, count=0.
4. Simultaneous push and pop:
   - Stimulus: with the FIFO full, assert write_en and read_en with block_in=0x05.
   - Required: count=4, overflow=0, head becomes 0x02, and drain order is 0x02, 0x03, 0x04, 0x05.
   - Empty case: write_en and read_en together -> count=1, underflow=1, block_out=block_in next cycle.
5. Wrap-around and clear:
   - Stimulus: 10 interleaved push/pop cycles (pointers wrap twice) with incrementing data.
   - Required: order preserved throughout.
   - Then with count=3, assert clear together with write_en.
   - Required next cycle: count=0, empty=1, flags 0, block_out=0.
6. WIDTH=224 build and async reset:
   - Stimulus: WIDTH=224 build; push 0x0123...; assert RST mid-cycle with count=2.
   - Required: full 224-bit data integrity on the push, and count=0 and block_out=0 before the next CLK edge after RST asserts.

Source files
------------

// File: rtl/mem_save_block_fifo.sv
// Purpose: FWFT FIFO buffering DEPTH hash blocks/digests between a SHA-2 core and its consumer.
// Latency: a push into an empty FIFO is visible on block_out one cycle after the write edge.
// Backpressure: full drops writes (sticky overflow) unless a pop happens in the same cycle; empty ignores reads (sticky underflow).
module mem_save_block_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             write_en,
    input  logic [WIDTH-1:0] block_in,
    input  logic             read_en,
    output logic [WIDTH-1:0] block_out,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    // Pointer width; DEPTH is a power of two so pointers wrap by plain overflow.
    localparam int PW = $clog2(DEPTH);

    // Storage is not reset: the head is masked to zero whenever the FIFO is empty.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full_w;
    logic          empty_w;
    logic          push_w;
    logic          pop_w;

    // Status decodes from the registered occupancy.
    always_comb begin
        full_w  = (count_q == CW'(DEPTH));
        empty_w = (count_q == '0);
    end

    // Accept decisions; clear overrides both requests. A pop frees a slot, so a
    // write while full is still taken when paired with a read. A read on an empty
    // FIFO is never satisfied from the same-cycle write.
    always_comb begin
        push_w = 1'b0;
        pop_w  = 1'b0;
        if (!clear) begin
            push_w = write_en && (!full_w || read_en);
            pop_w  = read_en && !empty_w;
        end
    end

    // Next-state for pointers, occupancy and the sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (write_en && full_w && !read_en) begin
                overflow_d = 1'b1;
            end
            if (read_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state register; reset empties the FIFO without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Data array write on an accepted push only.
    always_ff @(posedge CLK) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= block_in;
        end
    end

    // First-word-fall-through head, forced to zero when nothing is stored.
    always_comb begin
        block_out = '0;
        if (!empty_w) begin
            block_out = mem_q[rd_ptr_q];
        end
    end

    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_mem_save_block_fifo.sv
// Directed bench for mem_save_block_fifo: table of per-cycle vectors on a 256-bit build,
// plus hand-written sequences on a 224-bit build for data integrity and async reset.
module tb_mem_save_block_fifo;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 256-bit, DEPTH=4 instance
    logic         rst_a, clear_a, we_a, re_a;
    logic [255:0] din_a, out_a;
    logic         full_a, empty_a, ovf_a, udf_a;
    logic [2:0]   cnt_a;

    // 224-bit, DEPTH=4 instance
    logic         rst_b, clear_b, we_b, re_b;
    logic [223:0] din_b, out_b;
    logic         full_b, empty_b, ovf_b, udf_b;
    logic [2:0]   cnt_b;

    mem_save_block_fifo #(.WIDTH(256), .DEPTH(4)) dut_a (
        .CLK(CLK), .RST(rst_a), .clear(clear_a), .write_en(we_a), .block_in(din_a),
        .read_en(re_a), .block_out(out_a), .full(full_a), .empty(empty_a),
        .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
    );

    mem_save_block_fifo #(.WIDTH(224), .DEPTH(4)) dut_b (
        .CLK(CLK), .RST(rst_b), .clear(clear_b), .write_en(we_b), .block_in(din_b),
        .read_en(re_b), .block_out(out_b), .full(full_b), .empty(empty_b),
        .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
    );

    typedef struct {
        logic         clr;
        logic         we;
        logic         re;
        logic [255:0] din;
        int           cnt;
        logic [255:0] out;
        logic         ovf;
        logic         udf;
    } vec_t;

    vec_t vecs [64];
    int   nvec   = 0;
    int   passed = 0;
    int   total  = 0;

    task automatic add(input logic clr, input logic we, input logic re, input logic [255:0] din,
                       input int cnt, input logic [255:0] out, input logic ovf, input logic udf);
        vecs[nvec].clr = clr;
        vecs[nvec].we  = we;
        vecs[nvec].re  = re;
        vecs[nvec].din = din;
        vecs[nvec].cnt = cnt;
        vecs[nvec].out = out;
        vecs[nvec].ovf = ovf;
        vecs[nvec].udf = udf;
        nvec++;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [223:0] pat;

    initial begin
        rst_a = 1'b0; clear_a = 1'b0; we_a = 1'b0; re_a = 1'b0; din_a = '0;
        rst_b = 1'b0; clear_b = 1'b0; we_b = 1'b0; re_b = 1'b0; din_b = '0;
        pat   = 224'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4;

        // Fill and drain, overflow, underflow
        for (int i = 1; i <= 4; i++) begin
            add(0, 1, 0, 256'(i), i, 256'h1, 0, 0);
        end
        add(0, 1, 0, 256'hDEAD, 4, 256'h1, 1, 0);
        add(0, 0, 1, '0, 3, 256'h2, 1, 0);
        add(0, 0, 1, '0, 2, 256'h3, 1, 0);
        add(0, 0, 1, '0, 1, 256'h4, 1, 0);
        add(0, 0, 1, '0, 0, 256'h0, 1, 0);
        add(0, 0, 1, '0, 0, 256'h0, 1, 1);
        add(1, 0, 0, '0, 0, 256'h0, 0, 0);
        // Simultaneous push and pop, full then empty
        for (int i = 1; i <= 4; i++) begin
            add(0, 1, 0, 256'(i), i, 256'h1, 0, 0);
        end
        add(0, 1, 1, 256'h5, 4, 256'h2, 0, 0);
        add(0, 0, 1, '0, 3, 256'h3, 0, 0);
        add(0, 0, 1, '0, 2, 256'h4, 0, 0);
        add(0, 0, 1, '0, 1, 256'h5, 0, 0);
        add(0, 0, 1, '0, 0, 256'h0, 0, 0);
        add(0, 1, 1, 256'h6, 1, 256'h6, 0, 1);
        add(0, 0, 1, '0, 0, 256'h0, 0, 1);
        add(1, 0, 0, '0, 0, 256'h0, 0, 0);
        // Wrap-around: steady occupancy of 2, twelve pushes total
        add(0, 1, 0, 256'h10, 1, 256'h10, 0, 0);
        add(0, 1, 0, 256'h11, 2, 256'h10, 0, 0);
        for (int k = 0; k < 10; k++) begin
            add(0, 1, 1, 256'(32'h12 + k), 2, 256'(32'h11 + k), 0, 0);
        end
        add(0, 1, 0, 256'h1C, 3, 256'h1A, 0, 0);
        // Clear wins over a same-cycle write
        add(1, 1, 0, 256'hFF, 0, 256'h0, 0, 0);
        add(0, 0, 0, '0, 0, 256'h0, 0, 0);

        // Reset then idle
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_count", 256'(cnt_a), 256'h0);
        check("rst_empty", 256'(empty_a), 256'h1);
        check("rst_full", 256'(full_a), 256'h0);
        check("rst_out", out_a, 256'h0);
        check("rst_ovf", 256'(ovf_a), 256'h0);
        check("rst_udf", 256'(udf_a), 256'h0);

        for (int v = 0; v < nvec; v++) begin
            @(negedge CLK);
            clear_a = vecs[v].clr;
            we_a    = vecs[v].we;
            re_a    = vecs[v].re;
            din_a   = vecs[v].din;
            @(posedge CLK);
            #1;
            check($sformatf("v%0d_count", v), 256'(cnt_a), 256'(vecs[v].cnt));
            check($sformatf("v%0d_full", v), 256'(full_a), 256'(vecs[v].cnt == 4));
            check($sformatf("v%0d_empty", v), 256'(empty_a), 256'(vecs[v].cnt == 0));
            check($sformatf("v%0d_out", v), out_a, vecs[v].out);
            check($sformatf("v%0d_ovf", v), 256'(ovf_a), 256'(vecs[v].ovf));
            check($sformatf("v%0d_udf", v), 256'(udf_a), 256'(vecs[v].udf));
        end
        @(negedge CLK);
        clear_a = 1'b0; we_a = 1'b0; re_a = 1'b0; din_a = '0;

        // 224-bit data integrity
        we_b  = 1'b1;
        din_b = pat;
        @(posedge CLK);
        #1;
        check("w224_out1", 256'(out_b), 256'(pat));
        check("w224_cnt1", 256'(cnt_b), 256'h1);
        @(negedge CLK);
        din_b = ~pat;
        @(posedge CLK);
        #1;
        check("w224_cnt2", 256'(cnt_b), 256'h2);
        check("w224_head", 256'(out_b), 256'(pat));
        // Async reset mid-cycle, checked before the next rising edge
        @(negedge CLK);
        we_b  = 1'b0;
        din_b = '0;
        #2;
        rst_b = 1'b0;
        #1;
        check("arst_cnt", 256'(cnt_b), 256'h0);
        check("arst_out", 256'(out_b), 256'h0);
        check("arst_empty", 256'(empty_b), 256'h1);
        @(negedge CLK);
        rst_b = 1'b1;
        @(posedge CLK);
        #1;
        check("arst_after_cnt", 256'(cnt_b), 256'h0);
        check("arst_after_out", 256'(out_b), 256'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
